// File: rtl/morse_pkg.sv
// Shared definitions for the Morse symbol sequencer.
//   - Symbol code constants (letters, digits, word break)
//   - Default gap lengths in clock cycles
//   - Pattern record: element count plus left-aligned element bits (1 = dash)
//   - Sequencer state encoding
package morse_pkg;

  localparam logic [5:0] SYM_A      = 6'd0;
  localparam logic [5:0] SYM_DIGIT0 = 6'd26;
  localparam logic [5:0] SYM_WORD   = 6'd36;

  localparam int unsigned DEF_ELEM_GAP = 2;
  localparam int unsigned DEF_CHAR_GAP = 4;
  localparam int unsigned DEF_WORD_GAP = 8;

  localparam int unsigned PAT_LEN_W  = 3;
  localparam int unsigned PAT_BITS_W = 5;

  // bits[4] is the first element sent; unused trailing bits are zero.
  typedef struct packed {
    logic [PAT_LEN_W-1:0]  len;
    logic [PAT_BITS_W-1:0] bits;
  } pat_t;

  typedef enum logic [2:0] {
    StIdle,
    StElem,
    StElemWait,
    StChar,
    StCharWait,
    StWordWait
  } seq_state_e;

  // Builds a record from a right-aligned element string (first element in bit len-1).
  function automatic pat_t mk_pat(input logic [2:0] len, input logic [4:0] code);
    pat_t p;
    p.len  = len;
    p.bits = code << (3'd5 - len);
    return p;
  endfunction

endpackage

// File: rtl/morse_pattern_rom.sv
// Combinational Morse pattern table.
//   sym_code : symbol code (0-25 letters A-Z, 26-35 digits 0-9)
//   valid    : 1 when sym_code names a letter or digit
//   pat      : element count and left-aligned element bits (1 = dash)
module morse_pattern_rom
  import morse_pkg::*;
(
  input  logic [5:0] sym_code,
  output logic       valid,
  output pat_t       pat
);

  always_comb begin
    valid = 1'b1;
    pat   = '0;
    case (sym_code)
      SYM_A + 6'd0:       pat = mk_pat(3'd2, 5'b00001); // A .-
      SYM_A + 6'd1:       pat = mk_pat(3'd4, 5'b01000); // B -...
      SYM_A + 6'd2:       pat = mk_pat(3'd4, 5'b01010); // C -.-.
      SYM_A + 6'd3:       pat = mk_pat(3'd3, 5'b00100); // D -..
      SYM_A + 6'd4:       pat = mk_pat(3'd1, 5'b00000); // E .
      SYM_A + 6'd5:       pat = mk_pat(3'd4, 5'b00010); // F ..-.
      SYM_A + 6'd6:       pat = mk_pat(3'd3, 5'b00110); // G --.
      SYM_A + 6'd7:       pat = mk_pat(3'd4, 5'b00000); // H ....
      SYM_A + 6'd8:       pat = mk_pat(3'd2, 5'b00000); // I ..
      SYM_A + 6'd9:       pat = mk_pat(3'd4, 5'b00111); // J .---
      SYM_A + 6'd10:      pat = mk_pat(3'd3, 5'b00101); // K -.-
      SYM_A + 6'd11:      pat = mk_pat(3'd4, 5'b00100); // L .-..
      SYM_A + 6'd12:      pat = mk_pat(3'd2, 5'b00011); // M --
      SYM_A + 6'd13:      pat = mk_pat(3'd2, 5'b00010); // N -.
      SYM_A + 6'd14:      pat = mk_pat(3'd3, 5'b00111); // O ---
      SYM_A + 6'd15:      pat = mk_pat(3'd4, 5'b00110); // P .--.
      SYM_A + 6'd16:      pat = mk_pat(3'd4, 5'b01101); // Q --.-
      SYM_A + 6'd17:      pat = mk_pat(3'd3, 5'b00010); // R .-.
      SYM_A + 6'd18:      pat = mk_pat(3'd3, 5'b00000); // S ...
      SYM_A + 6'd19:      pat = mk_pat(3'd1, 5'b00001); // T -
      SYM_A + 6'd20:      pat = mk_pat(3'd3, 5'b00001); // U ..-
      SYM_A + 6'd21:      pat = mk_pat(3'd4, 5'b00001); // V ...-
      SYM_A + 6'd22:      pat = mk_pat(3'd3, 5'b00011); // W .--
      SYM_A + 6'd23:      pat = mk_pat(3'd4, 5'b01001); // X -..-
      SYM_A + 6'd24:      pat = mk_pat(3'd4, 5'b01011); // Y -.--
      SYM_A + 6'd25:      pat = mk_pat(3'd4, 5'b01100); // Z --..
      SYM_DIGIT0 + 6'd0:  pat = mk_pat(3'd5, 5'b11111); // 0 -----
      SYM_DIGIT0 + 6'd1:  pat = mk_pat(3'd5, 5'b01111); // 1 .----
      SYM_DIGIT0 + 6'd2:  pat = mk_pat(3'd5, 5'b00111); // 2 ..---
      SYM_DIGIT0 + 6'd3:  pat = mk_pat(3'd5, 5'b00011); // 3 ...--
      SYM_DIGIT0 + 6'd4:  pat = mk_pat(3'd5, 5'b00001); // 4 ....-
      SYM_DIGIT0 + 6'd5:  pat = mk_pat(3'd5, 5'b00000); // 5 .....
      SYM_DIGIT0 + 6'd6:  pat = mk_pat(3'd5, 5'b10000); // 6 -....
      SYM_DIGIT0 + 6'd7:  pat = mk_pat(3'd5, 5'b11000); // 7 --...
      SYM_DIGIT0 + 6'd8:  pat = mk_pat(3'd5, 5'b11100); // 8 ---..
      SYM_DIGIT0 + 6'd9:  pat = mk_pat(3'd5, 5'b11110); // 9 ----.
      default:            valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/morse_seq_ctrl.sv
// Symbol-level sequencer in front of the Morse translator. Accepts one symbol per
// valid/ready handshake and expands it into spaced one-cycle element/space pulses.
// Optional feature macro: MORSE_SEQ_ERR_EN adds the sym_err output.
//   clk, rst        : clock, asynchronous active-low reset
//   sym_valid       : symbol code valid
//   sym_code        : 0-25 A-Z, 26-35 digits, 36 word break, 37-63 invalid
//   sym_ready       : sequencer can accept a symbol
//   dot_out         : one-cycle dot request
//   dash_out        : one-cycle dash request
//   char_space_out  : one-cycle character-space request
//   word_space_out  : one-cycle word-space request
//   busy            : high whenever the sequencer is not idle
//   sym_err         : (MORSE_SEQ_ERR_EN) one-cycle pulse after an invalid code is accepted
module morse_seq_ctrl
  import morse_pkg::*;
#(
  parameter int unsigned ELEM_GAP = DEF_ELEM_GAP,
  parameter int unsigned CHAR_GAP = DEF_CHAR_GAP,
  parameter int unsigned WORD_GAP = DEF_WORD_GAP
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sym_valid,
  input  logic [5:0] sym_code,
  output logic       sym_ready,
  output logic       dot_out,
  output logic       dash_out,
  output logic       char_space_out,
  output logic       word_space_out,
  output logic       busy
`ifdef MORSE_SEQ_ERR_EN
  ,
  output logic       sym_err
`endif
);

  seq_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] rem_q, rem_d;
  logic [4:0] pat_q, pat_d;
  logic       ready_q, ready_d;
  logic       busy_q, busy_d;
  logic       dot_q, dot_d;
  logic       dash_q, dash_d;
  logic       cs_q, cs_d;
  logic       ws_q, ws_d;
`ifdef MORSE_SEQ_ERR_EN
  logic       err_q, err_d;
`endif

  logic rom_valid;
  pat_t rom_pat;
  logic accept;

  morse_pattern_rom u_rom (
    .sym_code (sym_code),
    .valid    (rom_valid),
    .pat      (rom_pat)
  );

  assign accept = sym_valid & ready_q;

  // Pulses are registered from the transition into their state, so each pulse is
  // visible in the first cycle that state is occupied.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    pat_d   = pat_q;
    dot_d   = 1'b0;
    dash_d  = 1'b0;
    cs_d    = 1'b0;
    ws_d    = 1'b0;
`ifdef MORSE_SEQ_ERR_EN
    err_d   = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (rom_valid) begin
            state_d = StElem;
            dash_d  = rom_pat.bits[4];
            dot_d   = ~rom_pat.bits[4];
            pat_d   = {rom_pat.bits[3:0], 1'b0};
            rem_d   = rom_pat.len - 3'd1;
          end else if (sym_code == SYM_WORD) begin
            state_d = StWordWait;
            ws_d    = 1'b1;
            // Pulse cycle is the first of the WORD_GAP cycles before ready returns.
            cnt_d   = 4'(WORD_GAP - 1);
          end else begin
            // Invalid code: consumed and dropped, only the ready bubble remains.
`ifdef MORSE_SEQ_ERR_EN
            err_d = 1'b1;
`endif
          end
        end
      end
      StElem: begin
        state_d = StElemWait;
        cnt_d   = 4'(ELEM_GAP - 2);
      end
      StElemWait: begin
        if (cnt_q == 4'd0) begin
          if (rem_q != 3'd0) begin
            state_d = StElem;
            dash_d  = pat_q[4];
            dot_d   = ~pat_q[4];
            pat_d   = {pat_q[3:0], 1'b0};
            rem_d   = rem_q - 3'd1;
          end else begin
            state_d = StChar;
            cs_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StChar: begin
        state_d = StCharWait;
        cnt_d   = 4'(CHAR_GAP - 2);
      end
      StCharWait, StWordWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    ready_d = (state_d == StIdle) && !accept;
    busy_d  = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rem_q   <= '0;
      pat_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      dot_q   <= 1'b0;
      dash_q  <= 1'b0;
      cs_q    <= 1'b0;
      ws_q    <= 1'b0;
`ifdef MORSE_SEQ_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      pat_q   <= pat_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      dot_q   <= dot_d;
      dash_q  <= dash_d;
      cs_q    <= cs_d;
      ws_q    <= ws_d;
`ifdef MORSE_SEQ_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  assign sym_ready      = ready_q;
  assign busy           = busy_q;
  assign dot_out        = dot_q;
  assign dash_out       = dash_q;
  assign char_space_out = cs_q;
  assign word_space_out = ws_q;
`ifdef MORSE_SEQ_ERR_EN
  assign sym_err        = err_q;
`endif

endmodule

// File: tb/tb_morse_seq_ctrl.sv
// Self-checking bench for morse_seq_ctrl. Expected waveforms come from a Morse text
// table and the gap arithmetic; a monitor checks pulse exclusivity and translator spacing.
module tb_morse_seq_ctrl;

  localparam int ELEM_GAP = 2;
  localparam int CHAR_GAP = 4;
  localparam int WORD_GAP = 8;
  localparam logic [6:0] IDLE_VEC = 7'b0000100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sym_valid = 1'b0;
  logic [5:0] sym_code = 6'd0;
  logic       sym_ready, dot_out, dash_out, char_space_out, word_space_out, busy;
  logic       err_obs;
  logic [6:0] obs;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  morse_seq_ctrl #(
    .ELEM_GAP (ELEM_GAP),
    .CHAR_GAP (CHAR_GAP),
    .WORD_GAP (WORD_GAP)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .sym_valid      (sym_valid),
    .sym_code       (sym_code),
    .sym_ready      (sym_ready),
    .dot_out        (dot_out),
    .dash_out       (dash_out),
    .char_space_out (char_space_out),
    .word_space_out (word_space_out),
    .busy           (busy)
`ifdef MORSE_SEQ_ERR_EN
    ,
    .sym_err        (err_obs)
`endif
  );

`ifndef MORSE_SEQ_ERR_EN
  assign err_obs = 1'b0;
`endif

  // {dot, dash, char_space, word_space, ready, busy, err}
  assign obs = {dot_out, dash_out, char_space_out, word_space_out, sym_ready, busy, err_obs};

  string morse_tab[36] = '{
    ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---", "-.-", ".-..",
    "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
    "-.--", "--..", "-----", ".----", "..---", "...--", "....-", ".....", "-....",
    "--...", "---..", "----."
  };

  // Cycle (after the accept cycle 0) in which sym_ready returns.
  function automatic int exp_len(int code);
    if (code < 36) return 1 + ELEM_GAP * morse_tab[code].len() + CHAR_GAP;
    if (code == 36) return 1 + WORD_GAP;
    return 2;
  endfunction

  function automatic logic [6:0] exp_vec(int code, int c);
    logic [6:0] v;
    int r;
    string s;
    v = '0;
    r = exp_len(code);
    v[2] = (c == 0) || (c >= r);
    v[1] = (c >= 1) && (c < r) && (code <= 36);
    if (code < 36) begin
      s = morse_tab[code];
      for (int i = 0; i < s.len(); i++) begin
        if (c == 1 + ELEM_GAP * i) begin
          if (s.getc(i) == 8'h2d) v[5] = 1'b1;
          else v[6] = 1'b1;
        end
      end
      if (c == 1 + ELEM_GAP * s.len()) v[4] = 1'b1;
    end else if (code == 36) begin
      if (c == 1) v[3] = 1'b1;
    end else begin
`ifdef MORSE_SEQ_ERR_EN
      if (c == 1) v[0] = 1'b1;
`endif
    end
    return v;
  endfunction

  // Translator model: after each pulse it stays busy for that pulse's gap.
  int last_pulse = -1000;
  int last_req = 0;
  always @(negedge clk) begin
    if (!rst) begin
      last_pulse = -1000;
    end else if (dot_out | dash_out | char_space_out | word_space_out) begin
      tests_run++;
      if ($countones({dot_out, dash_out, char_space_out, word_space_out}) != 1 ||
          cyc - last_pulse < last_req) begin
        tests_failed++;
        $display("FAIL translator_idle cyc=%0d pulses=%b gap=%0d need=%0d", cyc,
                 {dot_out, dash_out, char_space_out, word_space_out}, cyc - last_pulse,
                 last_req);
      end
      last_pulse = cyc;
      last_req = (dot_out | dash_out) ? ELEM_GAP : (char_space_out ? CHAR_GAP : WORD_GAP);
    end
  end

  task automatic test_reset();
    #2 rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (obs !== IDLE_VEC) begin
      tests_failed++;
      $display("FAIL reset_state got=%b exp=%b", obs, IDLE_VEC);
    end
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests_run++;
      if (obs !== IDLE_VEC) begin
        tests_failed++;
        $display("FAIL reset_idle k=%0d got=%b exp=%b", k, obs, IDLE_VEC);
      end
    end
  endtask

  task automatic test_letter_e();
    tests_run++;
    if (obs !== exp_vec(4, 0)) begin
      tests_failed++;
      $display("FAIL e_pre got=%b exp=%b", obs, exp_vec(4, 0));
    end
    sym_valid = 1'b1;
    sym_code  = 6'd4;
    for (int c = 1; c <= exp_len(4); c++) begin
      @(negedge clk);
      if (c == 1) begin
        sym_valid = 1'b0;
        sym_code  = 6'($urandom);
      end
      tests_run++;
      if (obs !== exp_vec(4, c)) begin
        tests_failed++;
        $display("FAIL letter_e cycle=%0d got=%b exp=%b", c, obs, exp_vec(4, c));
      end
    end
  endtask

  // S, T, then more symbols with no idle cycle between any of them.
  task automatic test_back_to_back();
    int codes[$] = '{18, 19, 26, 4, 36, 0};
    foreach (codes[n]) begin
      sym_valid = 1'b1;
      sym_code  = 6'(codes[n]);
      for (int c = 1; c <= exp_len(codes[n]); c++) begin
        @(negedge clk);
        if (c == 1) begin
          sym_valid = 1'b0;
          sym_code  = 6'($urandom);
        end
        tests_run++;
        if (obs !== exp_vec(codes[n], c)) begin
          tests_failed++;
          $display("FAIL back_to_back code=%0d cycle=%0d got=%b exp=%b", codes[n], c, obs,
                   exp_vec(codes[n], c));
        end
      end
    end
  endtask

  task automatic test_word_break();
    int codes[$] = '{36, 36, 5, 36};
    foreach (codes[n]) begin
      sym_valid = 1'b1;
      sym_code  = 6'(codes[n]);
      for (int c = 1; c <= exp_len(codes[n]); c++) begin
        @(negedge clk);
        if (c == 1) begin
          sym_valid = 1'b0;
          sym_code  = 6'($urandom);
        end
        tests_run++;
        if (obs !== exp_vec(codes[n], c)) begin
          tests_failed++;
          $display("FAIL word_break code=%0d cycle=%0d got=%b exp=%b", codes[n], c, obs,
                   exp_vec(codes[n], c));
        end
      end
    end
  endtask

  task automatic test_invalid();
    int codes[$] = '{40, 37, 63, 7, 40};
    foreach (codes[n]) begin
      sym_valid = 1'b1;
      sym_code  = 6'(codes[n]);
      for (int c = 1; c <= exp_len(codes[n]); c++) begin
        @(negedge clk);
        if (c == 1) begin
          sym_valid = 1'b0;
          sym_code  = 6'($urandom);
        end
        tests_run++;
        if (obs !== exp_vec(codes[n], c)) begin
          tests_failed++;
          $display("FAIL invalid code=%0d cycle=%0d got=%b exp=%b", codes[n], c, obs,
                   exp_vec(codes[n], c));
        end
      end
    end
  endtask

  task automatic test_random();
    int code;
    int gap;
    for (int n = 0; n < 40; n++) begin
      code = ($urandom_range(0, 3) == 0) ? int'($urandom_range(36, 63))
                                         : int'($urandom_range(0, 35));
      gap = $urandom_range(0, 2);
      for (int k = 0; k < gap; k++) begin
        @(negedge clk);
        tests_run++;
        if (obs !== IDLE_VEC) begin
          tests_failed++;
          $display("FAIL random_idle n=%0d got=%b exp=%b", n, obs, IDLE_VEC);
        end
      end
      sym_valid = 1'b1;
      sym_code  = 6'(code);
      for (int c = 1; c <= exp_len(code); c++) begin
        @(negedge clk);
        if (c == 1) begin
          sym_valid = 1'b0;
          sym_code  = 6'($urandom);
        end
        tests_run++;
        if (obs !== exp_vec(code, c)) begin
          tests_failed++;
          $display("FAIL random code=%0d cycle=%0d got=%b exp=%b", code, c, obs,
                   exp_vec(code, c));
        end
      end
    end
  endtask

  // Reset lands while the third dot of S is showing.
  task automatic test_reset_abort();
    sym_valid = 1'b1;
    sym_code  = 6'd18;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) begin
        sym_valid = 1'b0;
        sym_code  = 6'($urandom);
      end
      tests_run++;
      if (obs !== exp_vec(18, c)) begin
        tests_failed++;
        $display("FAIL abort_pre cycle=%0d got=%b exp=%b", c, obs, exp_vec(18, c));
      end
    end
    #1 rst = 1'b0;
    #1;
    tests_run++;
    if (obs !== IDLE_VEC) begin
      tests_failed++;
      $display("FAIL abort_async got=%b exp=%b", obs, IDLE_VEC);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      tests_run++;
      if (obs !== IDLE_VEC) begin
        tests_failed++;
        $display("FAIL abort_after k=%0d got=%b exp=%b", k, obs, IDLE_VEC);
      end
    end
  endtask

  initial begin
    test_reset();
    test_letter_e();
    test_back_to_back();
    test_word_break();
    test_invalid();
    test_random();
    test_reset_abort();
    test_letter_e();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/morse_seq_ctrl.md
Name: morse_seq_ctrl

Overview:
- Symbol-level sequencer placed in front of the Morse translator FSM.
- Accepts one symbol code per valid/ready handshake: letter, digit or word break.
- Expands the symbol through a pattern ROM into one-cycle dot, dash, char_space and word_space pulses.
- Spaces the pulses so every pulse reaches the translator while it is idle; the translator needs no flow control of its own.

Parameters:
- ELEM_GAP, 2: cycles from one element pulse to the next pulse (dot/dash → next). Legal range 2..15.
- CHAR_GAP, 4: cycles from a char_space pulse to the return of sym_ready. Legal range 4..15.
- WORD_GAP, 8: cycles from a word_space pulse to the return of sym_ready. Legal range 8..15.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- sym_valid  in  1  symbol code is valid
- sym_code  in  6  0–25 = A–Z; 26–35 = digits 0–9; 36 = word break; 37–63 invalid
- sym_ready  out  1  controller can accept a symbol
- dot_out  out  1  one-cycle dot request
- dash_out  out  1  one-cycle dash request
- char_space_out  out  1  one-cycle character-space request
- word_space_out  out  1  one-cycle word-space request
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE, all pulse outputs = 0, busy = 0, sym_ready = 1, counters cleared.
  - Reset asserted mid-symbol aborts the symbol; no further pulses are issued for it.
- All outputs are registered. Pulse outputs are mutually exclusive, at most one high per cycle.
- Handshake:
  - Accept occurs on the rising edge where sym_valid && sym_ready.
  - sym_ready drops in the cycle after acceptance and stays low until the state returns to IDLE.
  - sym_code is latched at accept; later changes on sym_code are ignored.
- States: IDLE, ELEM, ELEM_WAIT, CHAR, CHAR_WAIT, WORD_WAIT.
- IDLE:
  - On accept of a valid letter/digit: latch the pattern from the ROM (len 1..5; bits[4:0], MSB first, 1 = dash), go to ELEM.
  - On accept of code 36: word_space_out = 1 in the next cycle, go to WORD_WAIT.
  - On accept of codes 37–63: symbol is consumed and dropped; next state is IDLE with sym_ready = 1 one cycle later.
- ELEM: emit the current element (dot_out or dash_out) for one cycle, decrement the remaining count, go to ELEM_WAIT.
- ELEM_WAIT: hold ELEM_GAP-1 cycles, then go to ELEM if elements remain, otherwise to CHAR.
- CHAR: char_space_out = 1 for one cycle, go to CHAR_WAIT.
- CHAR_WAIT: hold CHAR_GAP-1 cycles, then go to IDLE.
- WORD_WAIT: hold WORD_GAP-1 cycles, then go to IDLE.
- Timing, letter E (defaults), accept in cycle 0:
  - dot_out in cycle 1.
  - char_space_out in cycle 3.
  - sym_ready = 1 in cycle 7.
- Throughput: the next symbol is accepted in the first ready cycle; its first pulse follows one cycle later, with no bubble beyond that.
- A word break after a letter is emitted as char_space followed by word_space. No merging is done.
- Gap counters are 4 bits wide; parameter values outside the legal ranges are unsupported.

Optional Feature:
- Macro MORSE_SEQ_ERR_EN.
- Defined:
  - Adds output port sym_err (1 bit, reset 0).
  - sym_err pulses high for exactly one cycle, the cycle after an invalid code (37–63) is accepted.
- Undefined:
  - The port is absent.
  - Invalid codes are silently consumed with identical handshake timing.

Decomposition:
- Shared package morse_pkg holds:
  - symbol code constants: SYM_A = 0, SYM_DIGIT0 = 26, SYM_WORD = 36.
  - state encodings.
  - default gap constants.
  - pattern record width (3-bit len + 5 bits).
- One sub-module, morse_pattern_rom: combinational, sym_code in, {valid, len, bits} out.

Test Plan:
- Reset, then send 'E' (4): dot_out in cycle 1, char_space_out in cycle 3, sym_ready back in cycle 7, no other pulses.
- 'S' (18) followed by 'T' (19) back-to-back:
  - dots in cycles 1, 3, 5; char_space in cycle 7.
  - T accepted in cycle 11; dash in cycle 12; char_space in cycle 14.
- Digit '0' (26): five dash pulses spaced 2 cycles apart, then char_space; busy high for the entire sequence.
- Word break (36): word_space_out in cycle 1, sym_ready in cycle 9. Translator model checked idle at every pulse.
- Invalid code 40: no pulses, sym_ready back after one cycle. With MORSE_SEQ_ERR_EN, sym_err = 1 for one cycle.
- rst low during the third dot of 'S': all outputs 0 immediately, sym_ready = 1 after release, no remaining pulses.
